// File: rtl/mismatch_checker_pkg.sv
// Shared types and parameter defaults for the output mismatch checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mismatch_checker_pkg;

    // Run-control states of the checker
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 1;
    localparam int DEF_CHANNELS = 1;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/mc_lane_compare.sv
// One channel of the checker: flags any bit difference between DUT and reference.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of the inputs.
module mc_lane_compare #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] r,
    output logic             diff
);

    assign diff = (y != r);

endmodule

// File: rtl/mismatch_checker.sv
// Compares CHANNELS lanes of DUT output against reference during a start/stop run and keeps error statistics.
// Latency: mismatch/ch_mismatch 1 cycle after the sample; counters and captures update on the same edge.
// Backpressure: none; a sample is accepted on every valid cycle while in RUN.
module mismatch_checker
    import mismatch_checker_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      valid,
    input  logic [CHANNELS*WIDTH-1:0] y,
    input  logic [CHANNELS*WIDTH-1:0] r,
    output logic                      mismatch,
    output logic [CHANNELS-1:0]       ch_mismatch,
    output logic [CNT_W-1:0]          sample_count,
    output logic [CNT_W-1:0]          err_count,
    output logic [CNT_W-1:0]          first_idx,
    output logic [CHANNELS-1:0]       first_ch,
    output logic                      busy,
    output logic                      done,
    output logic                      pass
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state;
    logic [CHANNELS-1:0] lane_diff;
    logic                any_diff;

    // Per-channel inequality, one comparator per lane
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        mc_lane_compare #(
            .WIDTH (WIDTH)
        ) u_lane (
            .y    (y[k*WIDTH +: WIDTH]),
            .r    (r[k*WIDTH +: WIDTH]),
            .diff (lane_diff[k])
        );
    end

    assign any_diff = |lane_diff;

    // Status flags decode straight from registered state and counters
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

    // Run-control FSM with all statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mismatch     <= 1'b0;
            ch_mismatch  <= '0;
            sample_count <= '0;
            err_count    <= '0;
            first_idx    <= '0;
            first_ch     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mismatch    <= 1'b0;
                    ch_mismatch <= '0;
                    // stop alongside start is irrelevant here: start wins
                    if (start) begin
                        state        <= RUN;
                        sample_count <= '0;
                        err_count    <= '0;
                        first_idx    <= '0;
                        first_ch     <= '0;
                    end
                end

                RUN: begin
                    if (valid) begin
                        mismatch    <= any_diff;
                        ch_mismatch <= lane_diff;
                        if (sample_count != CNT_MAX) begin
                            sample_count <= sample_count + CNT_ONE;
                        end
                        if (any_diff) begin
                            if (err_count != CNT_MAX) begin
                                err_count <= err_count + CNT_ONE;
                            end
                            // Only the first error of the run is captured;
                            // index is the count before this sample is added
                            if (err_count == '0) begin
                                first_idx <= sample_count;
                                first_ch  <= lane_diff;
                            end
                        end
                    end else begin
                        mismatch    <= 1'b0;
                        ch_mismatch <= '0;
                    end
                    // start is ignored while running; stop ends the run
                    // after the same-cycle sample has been taken
                    if (stop) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    mismatch    <= 1'b0;
                    ch_mismatch <= '0;
                    if (start) begin
                        state        <= RUN;
                        sample_count <= '0;
                        err_count    <= '0;
                        first_idx    <= '0;
                        first_ch     <= '0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    mismatch    <= 1'b0;
                    ch_mismatch <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mismatch_checker.sv
// Bench for mismatch_checker: three parameterisations driven serially on one clock.
// Latency: mismatch flags checked through a one-deep scoreboard, one cycle after each sample.
// Backpressure: none; stimulus is stepped one cycle per record.
module tb_mismatch_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- DUT A: WIDTH=8, CHANNELS=4, CNT_W=16 ----------------
    logic        a_start = 1'b0, a_stop = 1'b0, a_valid = 1'b0;
    logic [31:0] a_y = '0, a_r = '0;
    logic        a_mismatch, a_busy, a_done, a_pass;
    logic [3:0]  a_ch, a_fc;
    logic [15:0] a_sc, a_ec, a_fi;

    mismatch_checker #(.WIDTH(8), .CHANNELS(4), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .valid(a_valid),
        .y(a_y), .r(a_r), .mismatch(a_mismatch), .ch_mismatch(a_ch),
        .sample_count(a_sc), .err_count(a_ec), .first_idx(a_fi), .first_ch(a_fc),
        .busy(a_busy), .done(a_done), .pass(a_pass)
    );

    // ---------------- DUT B: defaults (WIDTH=1, CHANNELS=1) ----------------
    logic        b_start = 1'b0, b_stop = 1'b0, b_valid = 1'b0;
    logic [0:0]  b_y = '0, b_r = '0;
    logic        b_mismatch, b_busy, b_done, b_pass;
    logic [0:0]  b_ch, b_fc;
    logic [15:0] b_sc, b_ec, b_fi;

    mismatch_checker u_b (
        .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .valid(b_valid),
        .y(b_y), .r(b_r), .mismatch(b_mismatch), .ch_mismatch(b_ch),
        .sample_count(b_sc), .err_count(b_ec), .first_idx(b_fi), .first_ch(b_fc),
        .busy(b_busy), .done(b_done), .pass(b_pass)
    );

    // ---------------- DUT C: WIDTH=4, CHANNELS=2, CNT_W=2 ----------------
    logic        c_start = 1'b0, c_stop = 1'b0, c_valid = 1'b0;
    logic [7:0]  c_y = '0, c_r = '0;
    logic        c_mismatch, c_busy, c_done, c_pass;
    logic [1:0]  c_ch, c_fc;
    logic [1:0]  c_sc, c_ec, c_fi;

    mismatch_checker #(.WIDTH(4), .CHANNELS(2), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .stop(c_stop), .valid(c_valid),
        .y(c_y), .r(c_r), .mismatch(c_mismatch), .ch_mismatch(c_ch),
        .sample_count(c_sc), .err_count(c_ec), .first_idx(c_fi), .first_ch(c_fc),
        .busy(c_busy), .done(c_done), .pass(c_pass)
    );

    // One cycle of DUT A: inputs applied, then expected state after the edge
    typedef struct {
        logic        start, stop, valid;
        logic [31:0] y, r;
        logic        busy, done, pass;
        logic [15:0] sc, ec, fi;
        logic [3:0]  fc;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb_q[$];

    function automatic vec_t mk(input logic st, input logic sp, input logic v,
                                input logic [31:0] y, input logic [31:0] r,
                                input logic bz, input logic dn, input logic ps,
                                input logic [15:0] sc, input logic [15:0] ec,
                                input logic [15:0] fi, input logic [3:0] fc);
        vec_t t;
        t.start = st; t.stop = sp; t.valid = v; t.y = y; t.r = r;
        t.busy = bz; t.done = dn; t.pass = ps;
        t.sc = sc; t.ec = ec; t.fi = fi; t.fc = fc;
        return t;
    endfunction

    // Reference per-byte inequality for the 4x8 configuration
    function automatic logic [3:0] chan_diff(input logic [31:0] y, input logic [31:0] r);
        logic [3:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            d[k] = ((y >> (8 * k)) & 32'hFF) != ((r >> (8 * k)) & 32'hFF);
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic bz, input logic dn, input logic ps,
                         input logic [15:0] sc, input logic [15:0] ec,
                         input logic [15:0] fi, input logic [3:0] fc);
        chk({tag, ".busy"}, a_busy, bz);
        chk({tag, ".done"}, a_done, dn);
        chk({tag, ".pass"}, a_pass, ps);
        chk({tag, ".sample_count"}, a_sc, sc);
        chk({tag, ".err_count"}, a_ec, ec);
        chk({tag, ".first_idx"}, a_fi, fi);
        chk({tag, ".first_ch"}, a_fc, fc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       prev_busy;
        logic [3:0] exp_ch;

        // ---- stimulus table for DUT A ----
        vecs.push_back(mk(1,0,0, 32'h0,        32'h0,        1,0,0,  0,0,0,4'b0000)); // start from IDLE
        vecs.push_back(mk(0,0,1, 32'h00000000, 32'h00000000, 1,0,0,  1,0,0,4'b0000)); // s0
        vecs.push_back(mk(0,0,1, 32'hDEADBEEF, 32'hDEADBEEF, 1,0,0,  2,0,0,4'b0000)); // s1
        vecs.push_back(mk(0,0,1, 32'h12345678, 32'h12345678, 1,0,0,  3,0,0,4'b0000)); // s2
        vecs.push_back(mk(0,0,1, 32'hCAFEF00D, 32'hCA01F00D, 1,0,0,  4,1,3,4'b0100)); // s3 ch2 bad
        vecs.push_back(mk(0,0,1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,0,0,  5,1,3,4'b0100)); // s4
        vecs.push_back(mk(0,0,0, 32'h0,        32'hFFFFFFFF, 1,0,0,  5,1,3,4'b0100)); // bubble
        vecs.push_back(mk(0,0,1, 32'h0F0F0F0F, 32'h0F0F0F0F, 1,0,0,  6,1,3,4'b0100)); // s5
        vecs.push_back(mk(0,0,1, 32'h80808080, 32'h80808080, 1,0,0,  7,1,3,4'b0100)); // s6
        vecs.push_back(mk(0,0,1, 32'h13579BDF, 32'h13A89BDF, 1,0,0,  8,2,3,4'b0100)); // s7 ch2 bad
        vecs.push_back(mk(0,0,1, 32'h2468ACE0, 32'h2468ACE0, 1,0,0,  9,2,3,4'b0100)); // s8
        vecs.push_back(mk(0,0,1, 32'h55AA55AA, 32'h55AA55AA, 1,0,0, 10,2,3,4'b0100)); // s9
        vecs.push_back(mk(0,1,0, 32'h0,        32'h0,        0,1,0, 10,2,3,4'b0100)); // stop -> DONE
        vecs.push_back(mk(0,1,1, 32'h0,        32'hFFFFFFFF, 0,1,0, 10,2,3,4'b0100)); // DONE ignores valid/stop
        vecs.push_back(mk(1,0,0, 32'h0,        32'h0,        1,0,0,  0,0,0,4'b0000)); // restart from DONE
        vecs.push_back(mk(0,1,1, 32'hAABBCCDD, 32'h55BBCC22, 0,1,0,  1,1,0,4'b1001)); // stop + bad sample
        vecs.push_back(mk(1,1,0, 32'h0,        32'h0,        1,0,0,  0,0,0,4'b0000)); // start+stop in DONE
        vecs.push_back(mk(1,0,1, 32'h00001234, 32'h00001234, 1,0,0,  1,0,0,4'b0000)); // start ignored in RUN
        vecs.push_back(mk(1,1,1, 32'h0000FF00, 32'h00000000, 0,1,0,  2,1,1,4'b0010)); // start+stop = stop
        vecs.push_back(mk(0,0,0, 32'h0,        32'h0,        0,1,0,  2,1,1,4'b0010)); // hold

        // ---- reset state ----
        repeat (2) tick();
        chk("rst.mismatch", a_mismatch, 1'b0);
        chk("rst.ch_mismatch", a_ch, 4'b0);
        chk_a("rst", 0,0,0, 0,0,0,4'b0000);
        reset = 1'b0;
        tick();
        chk("idle.busy", a_busy, 1'b0);

        // ---- table-driven run on DUT A ----
        prev_busy = 1'b0;
        foreach (vecs[i]) begin
            a_start = vecs[i].start;
            a_stop  = vecs[i].stop;
            a_valid = vecs[i].valid;
            a_y     = vecs[i].y;
            a_r     = vecs[i].r;
            sb_q.push_back((prev_busy && vecs[i].valid) ? chan_diff(vecs[i].y, vecs[i].r) : 4'b0000);
            tick();
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL row%0d scoreboard: empty queue, expected an entry", i);
            end else begin
                exp_ch = sb_q.pop_front();
                chk($sformatf("row%0d.ch_mismatch", i), a_ch, exp_ch);
                chk($sformatf("row%0d.mismatch", i), a_mismatch, |exp_ch);
            end
            chk_a($sformatf("row%0d", i), vecs[i].busy, vecs[i].done, vecs[i].pass,
                  vecs[i].sc, vecs[i].ec, vecs[i].fi, vecs[i].fc);
            prev_busy = vecs[i].busy;
        end
        a_start = 0; a_stop = 0; a_valid = 0; a_y = '0; a_r = '0;

        // ---- reset in the middle of a run after two errors ----
        a_start = 1; tick(); a_start = 0;
        a_valid = 1; a_y = 32'h000000FF; a_r = 32'h0; tick();
        a_y = 32'hFF000000; tick();
        chk("mid.err_count", a_ec, 16'd2);
        chk("mid.mismatch", a_mismatch, 1'b1);
        reset = 1; a_start = 1; a_stop = 1; tick(); // reset outranks start/stop/valid
        chk("rstrun.mismatch", a_mismatch, 1'b0);
        chk("rstrun.ch_mismatch", a_ch, 4'b0);
        chk_a("rstrun", 0,0,0, 0,0,0,4'b0000);
        reset = 0; a_start = 0; a_stop = 0; a_valid = 0; tick();
        chk_a("rstidle", 0,0,0, 0,0,0,4'b0000);
        a_start = 1; tick(); a_start = 0;
        a_valid = 1; a_y = 32'h01020304; a_r = 32'h01020304; tick();
        a_valid = 0;
        chk_a("rerun", 1,0,0, 1,0,0,4'b0000);

        // ---- DUT B: single 1-bit channel, clean run ----
        b_start = 1; tick(); b_start = 0;
        chk("b.busy", b_busy, 1'b1);
        b_valid = 1; b_y = 1'b0; b_r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("b.s%0d.mismatch", i), b_mismatch, 1'b0);
        end
        b_valid = 0; b_stop = 1; tick(); b_stop = 0;
        chk("b.done", b_done, 1'b1);
        chk("b.pass", b_pass, 1'b1);
        chk("b.sample_count", b_sc, 16'd4);
        chk("b.err_count", b_ec, 16'd0);
        chk("b.first", {b_fi, b_fc, b_ch}, 18'd0);

        // ---- DUT C: counter saturation with CNT_W=2 ----
        c_start = 1; tick(); c_start = 0;
        c_valid = 1; c_y = 8'hF0; c_r = 8'h0F;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("c.s%0d.sample_count", i), c_sc, (i > 3) ? 2'd3 : 2'(i));
            chk($sformatf("c.s%0d.err_count", i), c_ec, (i > 3) ? 2'd3 : 2'(i));
            chk($sformatf("c.s%0d.ch_mismatch", i), c_ch, 2'b11);
        end
        c_valid = 0; c_stop = 1; tick(); c_stop = 0;
        chk("c.first_idx", c_fi, 2'd0);
        chk("c.first_ch", c_fc, 2'b11);
        chk("c.done", c_done, 1'b1);
        chk("c.pass", c_pass, 1'b0);
        chk("c.mismatch", c_mismatch, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mismatch_checker.md
MISMATCH_CHECKER -- requirements
Module: mismatch_checker

Interface
REQ-001 Parameter WIDTH, default 1, bits per channel; legal range 1..64.
REQ-002 Parameter CHANNELS, default 1, number of compared channels; legal range 1..16.
REQ-003 Parameter CNT_W, default 16, width of all counters and index outputs; legal range 2..32.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin a new check run; clears counters and captures.
REQ-007 stop  input  1  end the current run.
REQ-008 valid  input  1  y and r hold a sample to compare this cycle.
REQ-009 y  input  CHANNELS*WIDTH  DUT outputs; channel k at bits [k*WIDTH +: WIDTH].
REQ-010 r  input  CHANNELS*WIDTH  reference outputs; same packing as y.
REQ-011 mismatch  output  1  registered; set for one cycle after a compared sample differed on any channel.
REQ-012 ch_mismatch  output  CHANNELS  registered per-channel mismatch flags of the last compared sample.
REQ-013 sample_count  output  CNT_W  samples compared in the current or last run.
REQ-014 err_count  output  CNT_W  mismatching samples in the current or last run.
REQ-015 first_idx  output  CNT_W  sample index (0-based) of the first mismatching sample.
REQ-016 first_ch  output  CHANNELS  channel flags captured at the first mismatching sample.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  high in DONE.
REQ-019 pass  output  1  high in DONE when err_count is 0; low otherwise.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-021 In IDLE, start SHALL move to RUN and clear sample_count, err_count, first_idx, first_ch, mismatch and ch_mismatch.
REQ-022 In RUN, each cycle with valid=1 SHALL compare y against r per channel (bitwise inequality over WIDTH bits).
REQ-023 In RUN, valid=1 SHALL increment sample_count by 1 and saturate at all-ones.
REQ-024 In RUN, valid=1 with any channel differing SHALL increment err_count by 1 and saturate at all-ones.
REQ-025 first_idx and first_ch SHALL capture the pre-increment sample_count and the channel flags only when the mismatching sample is the first of the run (err_count was 0).
REQ-026 mismatch and ch_mismatch SHALL reflect the compared sample one cycle after it (latency 1), and read 0 after any cycle with valid=0 or outside RUN.
REQ-027 In RUN, stop SHALL move to DONE; a sample with valid=1 in the same cycle SHALL still be counted and compared.
REQ-028 In RUN, start SHALL be ignored; in RUN, start and stop together SHALL act as stop.
REQ-029 In DONE, counters and captures SHALL hold; start SHALL clear them and re-enter RUN.
REQ-030 In IDLE or DONE, valid and stop SHALL have no effect.
REQ-031 In IDLE, start and stop together SHALL enter RUN.
REQ-032 Once saturated, sample_count and err_count SHALL hold; first-mismatch capture SHALL remain correct up to saturation.

Reset
REQ-033 reset SHALL force IDLE and zero every output at the next rising edge, and SHALL take priority over start, stop and valid.
REQ-034 reset asserted in RUN SHALL discard the run; no partial result SHALL be presented on done or pass.

Structure
REQ-035 Package mismatch_checker_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default values of WIDTH, CHANNELS and CNT_W.
REQ-036 One sub-module, mc_lane_compare (per-channel WIDTH-bit inequality), SHALL be instantiated CHANNELS times.

Verification
REQ-037 WIDTH=1, CHANNELS=1: start, then 4 valid samples with y=r=0, then stop -> done=1, pass=1, sample_count=4, err_count=0.
REQ-038 WIDTH=8, CHANNELS=4: 10 samples with channel 2 wrong on samples 3 and 7 -> err_count=2, first_idx=3, first_ch=4'b0100, mismatch pulses one cycle after samples 3 and 7.
REQ-039 stop and a mismatching valid sample in the same cycle -> sample counted, err_count=1, then DONE with pass=0.
REQ-040 CNT_W=2: 6 mismatching samples -> sample_count=3, err_count=3 (saturated), first_idx=0.
REQ-041 reset mid-RUN after 2 errors -> next cycle IDLE, all outputs 0; a new start then counts from 0.
REQ-042 start in DONE after a failing run -> counters cleared, busy=1, done=0, pass=0.
